alu_job_sequencer: RTL and testbench
====================================

# alu_job_sequencer

Upstream command stage for the radix ALUs (`base2_alu` and its siblings). It buffers incoming operation commands in a small FIFO and issues them one at a time over the ALU's `start`/`busy`/`done` handshake. It measures per-operation latency in cycles, then returns a tagged result over a valid/ready response port. It also keeps running totals of operations and cycles, so the testbench can compare radix-optimised ALUs.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `TIMEOUT`, 255: maximum WAIT cycles before the job is abandoned (1..255).

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO not full
- `cmd_opcode`  in  4  opcode from `common_opcodes.vh`
- `cmd_a`, `cmd_b`  in  16 each  operands
- `cmd_tag`  in  4  caller tag, returned unchanged
- `alu_start`  out  1  one-cycle start pulse to ALU
- `alu_opcode`  out  4  held from ISSUE until job ends
- `alu_a`, `alu_b`  out  16 each  held from ISSUE until job ends
- `alu_busy`  in  1  ALU busy
- `alu_done`  in  1  ALU one-cycle completion pulse
- `alu_result`  in  32  ALU result, valid with `alu_done`
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts response
- `rsp_result`  out  32  captured result (0 on timeout)
- `rsp_tag`  out  4  tag of the job
- `rsp_cycles`  out  8  measured latency
- `rsp_timeout`  out  1  job abandoned
- `stat_ops`  out  16  accepted responses, wraps
- `stat_cycles`  out  32  sum of `rsp_cycles` over accepted responses, wraps

## Operation
- Command push occurs when `cmd_valid && cmd_ready`. `cmd_ready = !full`. The opcode is not decoded and is passed through unchanged.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- **IDLE**: if the FIFO is non-empty, pop the head into the job register (opcode, a, b, tag), then go to ISSUE.
- **ISSUE**: `alu_start = 1` only in this state. If `alu_busy == 0`, go to WAIT and load the wait counter with 1. Otherwise stay in ISSUE with start held.
- **WAIT**: counter increments each cycle and saturates at 255.
  - On `alu_done`: capture `alu_result` and the counter into `rsp_cycles`, set `rsp_timeout = 0`, go to RESP.
  - Else if counter == `TIMEOUT`: `rsp_result = 0`, `rsp_cycles = TIMEOUT`, `rsp_timeout = 1`, go to RESP.
  - If `alu_done` and the timeout condition occur in the same cycle, done wins.
- **RESP**: `rsp_valid = 1`, with all `rsp_*` stable until `rsp_ready`.
  - On handshake: `stat_ops += 1` and `stat_cycles += rsp_cycles`.
  - Then pop the next command directly into ISSUE if the FIFO is non-empty, else go to IDLE.
- `alu_done` outside WAIT is ignored. A late done after a timeout is dropped. The next ISSUE stalls on `alu_busy`.
- The FIFO keeps accepting pushes in every state. Responses leave in command order.

## Timing
- Reset values:
  - state IDLE, FIFO empty, `cmd_ready = 1`
  - `alu_start = 0`, `alu_opcode/a/b = 0`
  - `rsp_valid = 0`, `rsp_result = 0`, `rsp_tag = 0`, `rsp_cycles = 0`, `rsp_timeout = 0`
  - stats 0
- Reset mid-job discards the job and the FIFO contents, and no response is produced. The ALU shares `rst`, so no stale `done` can occur.
- Timeline for a command pushed in cycle P into an empty, idle block:
  - IDLE pops in P+1.
  - ISSUE in P+2 (T).
  - For an ALU with latency L: `alu_done` in T+1+L, and `rsp_cycles = L+1`.
  - `rsp_valid` first high in T+L+2.
- Back-to-back throughput: one job per L+3 cycles when `rsp_ready` is held high.
- `alu_start` is registered-state decoded and never high for two jobs without an intervening WAIT.

## Structure
- Opcodes stay in `common_opcodes.vh`. Add `SEQ_ST_*` state encodings and the command width (`SEQ_CMD_W = 40`) there as well.
- One sub-module, `cmd_fifo`: synchronous, `DEPTH` × 40 bits (opcode|a|b|tag).
  - Pointers carry one extra wrap bit for full/empty.
  - Push and pop in the same cycle are allowed when non-empty.
  - Push when full is ignored.

## Test plan
- `OP_BIN_ADD`, a=3, b=4, `base2_alu` with LAT_BIN=1, `rsp_ready = 1` → `rsp_result = 7`, `rsp_cycles = 2`, `rsp_timeout = 0`, `rsp_valid` in P+5.
- `OP_DEC_MUL10`, a=1234, LAT_DEC=8 → `rsp_result = 12340`, `rsp_cycles = 9`.
- Six commands with tags 0..5 pushed back-to-back, `rsp_ready = 0`, DEPTH=4 → one job in the register and four in the FIFO; `cmd_ready` drops at the sixth push. Release `rsp_ready` → tags 0..5 return in order with correct results.
- TIMEOUT=4 with an ALU stub that raises busy and never asserts done → `rsp_timeout = 1`, `rsp_result = 0`, `rsp_cycles = 4`. The next job holds `alu_start` while busy.
- `rst` asserted in the third WAIT cycle → next cycle all outputs are at reset values, `cmd_ready = 1`, and no response follows.
- Three `OP_BIN_SUB` jobs at LAT_BIN=1 → `stat_ops = 3`, `stat_cycles = 6`. Then 5−7 → `rsp_result = 32'h0000FFFE` (truncated 16-bit difference zero-extended to 32 bits).

Source files
------------

// File: rtl/alu_job_sequencer_pkg.sv
// Shared opcodes, sequencer state encodings and the packed command layout
// used by alu_job_sequencer and its command FIFO.
package alu_job_sequencer_pkg;

    localparam int SEQ_CMD_W = 40;

    // Radix ALU opcodes; the sequencer passes these through undecoded.
    localparam logic [3:0] OP_BIN_ADD   = 4'h0;
    localparam logic [3:0] OP_BIN_SUB   = 4'h1;
    localparam logic [3:0] OP_BIN_MUL   = 4'h2;
    localparam logic [3:0] OP_DEC_ADD   = 4'h8;
    localparam logic [3:0] OP_DEC_MUL10 = 4'h9;

    typedef enum logic [1:0] {
        SEQ_ST_IDLE  = 2'd0,
        SEQ_ST_ISSUE = 2'd1,
        SEQ_ST_WAIT  = 2'd2,
        SEQ_ST_RESP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
    } seq_cmd_t;

endpackage

// File: rtl/alu_job_sequencer_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module cmd_fifo
    import alu_job_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  seq_cmd_t push_data,
    input  logic     pop,
    output seq_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [SEQ_CMD_W-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = seq_cmd_t'(mem[rd_ptr[AW-1:0]]);

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_job_sequencer.sv
// Buffers ALU commands, issues them one at a time over start/busy/done,
// times each job and returns a tagged response plus running statistics.
module alu_job_sequencer
    import alu_job_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_tag,
    output logic        alu_start,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_busy,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_tag,
    output logic [7:0]  rsp_cycles,
    output logic        rsp_timeout,
    output logic [15:0] stat_ops,
    output logic [31:0] stat_cycles
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    seq_state_t state_q;
    seq_state_t state_d;
    seq_cmd_t   job_q;
    seq_cmd_t   fifo_head;
    seq_cmd_t   cmd_in;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] wait_cnt_q;
    logic       timed_out;

    assign cmd_in    = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, tag: cmd_tag};
    assign cmd_ready = !fifo_full;

    cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign alu_start  = (state_q == SEQ_ST_ISSUE);
    assign rsp_valid  = (state_q == SEQ_ST_RESP);
    assign alu_opcode = job_q.opcode;
    assign alu_a      = job_q.a;
    assign alu_b      = job_q.b;
    assign timed_out  = (wait_cnt_q == TIMEOUT_CNT);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            SEQ_ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = SEQ_ST_ISSUE;
                end
            end
            SEQ_ST_ISSUE: begin
                if (!alu_busy) state_d = SEQ_ST_WAIT;
            end
            SEQ_ST_WAIT: begin
                if (alu_done || timed_out) state_d = SEQ_ST_RESP;
            end
            SEQ_ST_RESP: begin
                // Chain straight into the next job so back-to-back work skips IDLE.
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = SEQ_ST_ISSUE;
                    end else begin
                        state_d  = SEQ_ST_IDLE;
                    end
                end
            end
            default: state_d = SEQ_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEQ_ST_IDLE;
            job_q       <= '0;
            wait_cnt_q  <= '0;
            rsp_result  <= '0;
            rsp_tag     <= '0;
            rsp_cycles  <= '0;
            rsp_timeout <= 1'b0;
            stat_ops    <= '0;
            stat_cycles <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) job_q <= fifo_head;
            case (state_q)
                SEQ_ST_ISSUE: begin
                    if (!alu_busy) wait_cnt_q <= 8'd1;
                end
                SEQ_ST_WAIT: begin
                    if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
                    // A done arriving on the timeout cycle still counts as a completion.
                    if (alu_done) begin
                        rsp_result  <= alu_result;
                        rsp_cycles  <= wait_cnt_q;
                        rsp_timeout <= 1'b0;
                        rsp_tag     <= job_q.tag;
                    end else if (timed_out) begin
                        rsp_result  <= '0;
                        rsp_cycles  <= TIMEOUT_CNT;
                        rsp_timeout <= 1'b1;
                        rsp_tag     <= job_q.tag;
                    end
                end
                SEQ_ST_RESP: begin
                    if (rsp_ready) begin
                        stat_ops    <= stat_ops + 16'd1;
                        stat_cycles <= stat_cycles + 32'(rsp_cycles);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_job_sequencer.sv
// Bench for alu_job_sequencer: an ALU stub with per-job latency, a reference
// model of the response rules, table vectors, directed corners and random traffic.
module tb_alu_job_sequencer;
    import alu_job_sequencer_pkg::*;

    localparam int TO = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic        alu_start;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_busy;
    logic        alu_done;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic [7:0]  rsp_cycles;
    logic        rsp_timeout;
    logic [15:0] stat_ops;
    logic [31:0] stat_cycles;

    alu_job_sequencer #(.DEPTH(4), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_tag     (cmd_tag),
        .alu_start   (alu_start),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_busy    (alu_busy),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_cycles  (rsp_cycles),
        .rsp_timeout (rsp_timeout),
        .stat_ops    (stat_ops),
        .stat_cycles (stat_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  tag;
        logic [7:0]  cycles;
        logic        timeout;
    } rsp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        int          lat;
        logic [31:0] exp_result;
        logic [7:0]  exp_cycles;
        logic        exp_timeout;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   lat_q[$];
    rsp_t exp_q[$];
    int   model_ops = 0;
    longint model_cycles = 0;
    bit   mon_en = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] diff;
        diff = a - b;
        case (op)
            OP_BIN_ADD:   return 32'(a) + 32'(b);
            OP_BIN_SUB:   return {16'h0000, diff};
            OP_DEC_MUL10: return 32'(a) * 32'd10;
            default:      return {a, b};
        endcase
    endfunction

    // Expected response: the ALU finishes after lat cycles, measured as lat+1;
    // anything that would exceed TO is reported as a timeout instead.
    function automatic rsp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] tag, input int lat);
        rsp_t r;
        r.tag = tag;
        if (lat + 1 <= TO) begin
            r.result  = alu_fn(op, a, b);
            r.cycles  = 8'(lat + 1);
            r.timeout = 1'b0;
        end else begin
            r.result  = 32'd0;
            r.cycles  = 8'(TO);
            r.timeout = 1'b1;
        end
        return r;
    endfunction

    // ALU stub: accepts start when idle, stays busy, pulses done lat cycles later.
    logic        stub_busy;
    logic [7:0]  stub_cnt;
    logic [31:0] stub_res;
    int          stub_lat;
    assign alu_busy   = stub_busy;
    assign alu_done   = stub_busy && (stub_cnt == 8'd0);
    assign alu_result = stub_res;

    always @(posedge clk) begin
        if (rst) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 8'd0;
            stub_res  <= 32'd0;
        end else if (stub_busy) begin
            if (stub_cnt == 8'd0) stub_busy <= 1'b0;
            else                  stub_cnt  <= stub_cnt - 8'd1;
        end else if (alu_start) begin
            stub_lat   = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
            stub_busy <= 1'b1;
            stub_cnt  <= 8'(stub_lat);
            stub_res  <= alu_fn(alu_opcode, alu_a, alu_b);
        end
    end

    always @(negedge clk) begin
        if (!rst && mon_en && rsp_valid && rsp_ready) begin
            check("rsp expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_result",  rsp_result, e.result);
                check("rsp_tag",     32'(rsp_tag), 32'(e.tag));
                check("rsp_cycles",  32'(rsp_cycles), 32'(e.cycles));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
                model_ops++;
                model_cycles += longint'(e.cycles);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input int lat, input bit track);
        bit acc = 1'b0;
        lat_q.push_back(lat);
        if (track) exp_q.push_back(model(op, a, b, tag, lat));
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        cmd_valid = 1'b0;
        check("push accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " cmd_ready"},   32'(cmd_ready), 32'd1);
        check({pfx, " alu_start"},   32'(alu_start), 32'd0);
        check({pfx, " alu_opcode"},  32'(alu_opcode), 32'd0);
        check({pfx, " alu_a"},       32'(alu_a), 32'd0);
        check({pfx, " alu_b"},       32'(alu_b), 32'd0);
        check({pfx, " rsp_valid"},   32'(rsp_valid), 32'd0);
        check({pfx, " rsp_result"},  rsp_result, 32'd0);
        check({pfx, " rsp_tag"},     32'(rsp_tag), 32'd0);
        check({pfx, " rsp_cycles"},  32'(rsp_cycles), 32'd0);
        check({pfx, " rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        check({pfx, " stat_ops"},    32'(stat_ops), 32'd0);
        check({pfx, " stat_cycles"}, stat_cycles, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        bit got;
        int seen;

        vecs[0] = '{OP_DEC_MUL10, 16'd1234,   16'd0,      4'd1, 8,  32'd12340,   8'd9, 1'b0};
        vecs[1] = '{OP_BIN_SUB,   16'd5,      16'd7,      4'd2, 1,  32'h0000FFFE, 8'd2, 1'b0};
        vecs[2] = '{OP_BIN_ADD,   16'hFFFF,   16'hFFFF,   4'd3, 1,  32'h0001FFFE, 8'd2, 1'b0};
        vecs[3] = '{OP_BIN_ADD,   16'd1,      16'd2,      4'd4, 9,  32'd0,       8'd9, 1'b1};
        vecs[4] = '{OP_BIN_SUB,   16'd9,      16'd1,      4'd5, 2,  32'd8,       8'd3, 1'b0};
        vecs[5] = '{OP_DEC_MUL10, 16'd7,      16'd0,      4'd6, 40, 32'd0,       8'd9, 1'b1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_opcode = '0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_tag = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Three subtractions at latency 1 accumulate 3 ops and 6 cycles.
        mon_en = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(OP_BIN_SUB, 16'(10 + i), 16'd3, 4'(i), 1, 1'b1);
        drain(200, "stats drain");
        check("stat_ops 3 subs", 32'(stat_ops), 32'd3);
        check("stat_cycles 3 subs", stat_cycles, 32'd6);

        // First response latency: push in P, rsp_valid first high in P+5.
        push(OP_BIN_ADD, 16'd3, 16'd4, 4'd7, 1, 1'b1);
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        check("first rsp seen", 32'(got), 32'd1);
        check("first rsp cycle offset", 32'(cyc), 32'd5);
        @(posedge clk);
        #1;
        drain(50, "latency drain");

        mon_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].lat, 1'b0);
            got = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            check($sformatf("vec%0d valid", i), 32'(got), 32'd1);
            check($sformatf("vec%0d result", i), rsp_result, vecs[i].exp_result);
            check($sformatf("vec%0d tag", i), 32'(rsp_tag), 32'(vecs[i].tag));
            check($sformatf("vec%0d cycles", i), 32'(rsp_cycles), 32'(vecs[i].exp_cycles));
            check($sformatf("vec%0d timeout", i), 32'(rsp_timeout), 32'(vecs[i].exp_timeout));
            @(posedge clk);
            #1;
            model_ops++;
            model_cycles += longint'(vecs[i].exp_cycles);
        end
        mon_en = 1'b1;

        // After the hung job times out, the next ISSUE holds start while busy.
        push(OP_BIN_ADD, 16'd3, 16'd4, 4'd8, 1, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (alu_start) begin
                got = 1'b1;
                break;
            end
        end
        check("stall start seen", 32'(got), 32'd1);
        check("stall busy", 32'(alu_busy), 32'd1);
        check("stall alu_opcode", 32'(alu_opcode), 32'(OP_BIN_ADD));
        check("stall alu_a", 32'(alu_a), 32'd3);
        check("stall alu_b", 32'(alu_b), 32'd4);
        @(negedge clk);
        check("start held while busy", 32'(alu_start), 32'd1);
        @(posedge clk);
        #1;
        drain(200, "stall drain");
        check("stat_ops model", 32'(stat_ops), 32'(model_ops));
        check("stat_cycles model", stat_cycles, 32'(model_cycles));

        // Fill: one job in the register, four in the FIFO, sixth push blocked.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(OP_BIN_SUB, 16'(i * 3), 16'(i), 4'(i), 1, 1'b1);
        check("full cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held rsp_valid", 32'(rsp_valid), 32'd1);
            check("held rsp_tag", 32'(rsp_tag), 32'd0);
            check("held cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        push(OP_BIN_SUB, 16'd15, 16'd5, 4'd5, 1, 1'b1);
        drain(200, "fill drain");

        // Reset during the third WAIT cycle discards the job silently.
        push(OP_BIN_ADD, 16'd1, 16'd1, 4'd9, 20, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (alu_start) begin
                got = 1'b1;
                break;
            end
        end
        check("rst job start seen", 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat_q.delete();
        exp_q.delete();
        model_ops = 0;
        model_cycles = 0;
        check_reset_outputs("midwait");
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no rsp after reset", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure against the reference model.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 2))
                0:       op = OP_BIN_ADD;
                1:       op = OP_BIN_SUB;
                default: op = OP_DEC_MUL10;
            endcase
            push(op, 16'($urandom), 16'($urandom), 4'($urandom), int'($urandom_range(1, 11)), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        rsp_ready = 1'b1;
        drain(3000, "random drain");
        check("random stat_ops", 32'(stat_ops), 32'(model_ops));
        check("random stat_cycles", stat_cycles, 32'(model_cycles));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
